// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline sequencer: jump cause codes, hold codes,
// sequencer state encoding and default widths.
package pipe_ctrl_pkg;

   localparam int ADDR_W_DEF    = 32;
   localparam int CAUSE_W_DEF   = 3;
   localparam int HOLD_W_DEF    = 3;
   localparam int FLUSH_CYC_DEF = 2;

   // Clean drain cycles (no EX/bus stall) needed before the core counts as halted.
   localparam int DRAIN_CYC = 3;

   typedef enum logic [2:0] {
      CAUSE_NONE        = 3'd0,
      CAUSE_NOCOND      = 3'd1,
      CAUSE_PRED_NO_YES = 3'd2,
      CAUSE_PRED_YES_NO = 3'd3,
      CAUSE_INT         = 3'd4,
      CAUSE_EXC         = 3'd5
   } cause_e;

   typedef enum logic [2:0] {
      HOLD_NONE     = 3'd0,
      HOLD_PC       = 3'd1,
      HOLD_PC_IF    = 3'd2,
      HOLD_PC_IF_ID = 3'd3,
      HOLD_ALL      = 3'd4
   } hold_e;

   typedef enum logic [1:0] {
      ST_RUN    = 2'd0,
      ST_FLUSH  = 2'd1,
      ST_DRAIN  = 2'd2,
      ST_HALTED = 2'd3
   } state_e;

endpackage

// File: rtl/pipe_ctrl_if.sv
// Handshake bundle between the sequencer and ex/mem/clint/jtag/pc.
// master: the sequencer itself; slave: the surrounding core blocks.
interface pipe_ctrl_if #(
   parameter int ADDR_W  = 32,
   parameter int CAUSE_W = 3,
   parameter int HOLD_W  = 3
);
   logic               exc_req_i;
   logic [ADDR_W-1:0]  exc_addr_i;
   logic [ADDR_W-1:0]  exc_pc_i;
   logic               exc_ack_o;
   logic               ex_jump_req_i;
   logic [CAUSE_W-1:0] ex_cause_i;
   logic [ADDR_W-1:0]  ex_from_i;
   logic [ADDR_W-1:0]  ex_to_i;
   logic               int_req_i;
   logic [ADDR_W-1:0]  int_addr_i;
   logic               int_ack_o;
   logic               ex_hold_i;
   logic               mem_hold_i;
   logic               halt_req_i;
   logic               resume_i;
   logic               halted_o;
   logic [CAUSE_W-1:0] jump_cause_o;
   logic [ADDR_W-1:0]  jump_to_o;
   logic [ADDR_W-1:0]  jump_from_o;
   logic [HOLD_W-1:0]  hold_flag_o;
   logic               flush_o;

   modport master (
      input  exc_req_i, exc_addr_i, exc_pc_i,
      input  ex_jump_req_i, ex_cause_i, ex_from_i, ex_to_i,
      input  int_req_i, int_addr_i,
      input  ex_hold_i, mem_hold_i, halt_req_i, resume_i,
      output exc_ack_o, int_ack_o, halted_o,
      output jump_cause_o, jump_to_o, jump_from_o, hold_flag_o, flush_o
   );

   modport slave (
      output exc_req_i, exc_addr_i, exc_pc_i,
      output ex_jump_req_i, ex_cause_i, ex_from_i, ex_to_i,
      output int_req_i, int_addr_i,
      output ex_hold_i, mem_hold_i, halt_req_i, resume_i,
      input  exc_ack_o, int_ack_o, halted_o,
      input  jump_cause_o, jump_to_o, jump_from_o, hold_flag_o, flush_o
   );

endinterface

// File: rtl/pipe_ctrl_arb.sv
// Combinational redirect arbiter: exception > EX jump > interrupt, with the
// per-source acceptance rules that depend on sequencer state and stalls.
module pipe_ctrl_arb
   import pipe_ctrl_pkg::*;
#(
   parameter int ADDR_W  = ADDR_W_DEF,
   parameter int CAUSE_W = CAUSE_W_DEF
) (
   input  logic               en,
   input  state_e             state,
   input  logic               exc_req,
   input  logic [ADDR_W-1:0]  exc_addr,
   input  logic [ADDR_W-1:0]  exc_pc,
   input  logic               ex_jump_req,
   input  logic [CAUSE_W-1:0] ex_cause,
   input  logic [ADDR_W-1:0]  ex_from,
   input  logic [ADDR_W-1:0]  ex_to,
   input  logic               int_req,
   input  logic [ADDR_W-1:0]  int_addr,
   input  logic               ex_hold,
   input  logic               mem_hold,
   input  logic               halt_req,
   output logic               exc_ack,
   output logic               int_ack,
   output logic               redirect,
   output logic [CAUSE_W-1:0] cause,
   output logic [ADDR_W-1:0]  jump_to,
   output logic [ADDR_W-1:0]  jump_from
);

   logic exc_ok;
   logic ex_ok;
   logic int_ok;

   // Exceptions are taken in every state but HALTED; a bus stall defers them
   // (the request is a level, so it is simply seen again later).
   assign exc_ok = en && exc_req && !mem_hold && (state != ST_HALTED);
   // EX redirects only in RUN; while the bus stalls EX keeps the request itself.
   assign ex_ok  = en && ex_jump_req && (state == ST_RUN) && !mem_hold;
   // Interrupts wait for a quiet pipeline and no pending debug halt.
   assign int_ok = en && int_req && (state == ST_RUN) && !ex_hold && !mem_hold && !halt_req;

   assign redirect = exc_ok || ex_ok || int_ok;

   // Priority select of the single redirect presented to pc.
   always_comb begin
      // NOTE: every output gets a default before any branch, so no path leaves it unassigned and no latch is inferred.
      exc_ack   = 1'b0;
      int_ack   = 1'b0;
      cause     = CAUSE_W'(CAUSE_NONE);
      jump_to   = '0;
      jump_from = '0;
      if (exc_ok) begin
         exc_ack   = 1'b1;
         cause     = CAUSE_W'(CAUSE_EXC);
         jump_to   = exc_addr;
         jump_from = exc_pc;
      end else if (ex_ok) begin
         cause     = ex_cause;
         jump_to   = ex_to;
         jump_from = ex_from;
      end else if (int_ok) begin
         int_ack   = 1'b1;
         cause     = CAUSE_W'(CAUSE_INT);
         jump_to   = int_addr;
      end
   end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer top: redirect arbitration (via pipe_ctrl_arb), stall
// merging into hold_flag_o, post-redirect flush bubbles and the JTAG
// halt/resume state machine.
// Optional feature macro: PIPE_CTRL_PERF_EN adds four 32-bit wrapping event
// counters and their output ports.
module pipe_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int ADDR_W    = ADDR_W_DEF,
   parameter int CAUSE_W   = CAUSE_W_DEF,
   parameter int HOLD_W    = HOLD_W_DEF,
   parameter int FLUSH_CYC = FLUSH_CYC_DEF
) (
   input  logic        clk,
   input  logic        rst_n,
   pipe_ctrl_if.master bus
`ifdef PIPE_CTRL_PERF_EN
   ,
   output logic [31:0] mispredict_cnt_o,
   output logic [31:0] int_cnt_o,
   output logic [31:0] exc_cnt_o,
   output logic [31:0] stall_cnt_o
`endif
);

   localparam int FCNT_W = 3;

   state_e             state_q, state_d;
   logic               flush_q, flush_d;
   logic [FCNT_W-1:0]  flush_cnt_q, flush_cnt_d;
   logic [1:0]         drain_cnt_q, drain_cnt_d;
   logic               halted_q;
   hold_e              hold;

   logic               redirect;
   logic               exc_ack;
   logic               int_ack;
   logic [CAUSE_W-1:0] cause;
   logic [ADDR_W-1:0]  jump_to;
   logic [ADDR_W-1:0]  jump_from;

   // Redirect outputs are combinational; reset gates them so acks drop at once.
   pipe_ctrl_arb #(
      .ADDR_W  (ADDR_W),
      .CAUSE_W (CAUSE_W)
   ) u_arb (
      .en          (rst_n),
      .state       (state_q),
      .exc_req     (bus.exc_req_i),
      .exc_addr    (bus.exc_addr_i),
      .exc_pc      (bus.exc_pc_i),
      .ex_jump_req (bus.ex_jump_req_i),
      .ex_cause    (bus.ex_cause_i),
      .ex_from     (bus.ex_from_i),
      .ex_to       (bus.ex_to_i),
      .int_req     (bus.int_req_i),
      .int_addr    (bus.int_addr_i),
      .ex_hold     (bus.ex_hold_i),
      .mem_hold    (bus.mem_hold_i),
      .halt_req    (bus.halt_req_i),
      .exc_ack     (exc_ack),
      .int_ack     (int_ack),
      .redirect    (redirect),
      .cause       (cause),
      .jump_to     (jump_to),
      .jump_from   (jump_from)
   );

   // Next-state logic: flush bubble timer plus RUN/FLUSH/DRAIN/HALTED sequencing.
   always_comb begin
      state_d     = state_q;
      flush_d     = flush_q;
      flush_cnt_d = flush_cnt_q;
      drain_cnt_d = drain_cnt_q;

      // The flush timer runs in any state so an exception taken while
      // draining still kills the wrong-path instructions behind it.
      if (redirect) begin
         flush_d     = 1'b1;
         flush_cnt_d = FCNT_W'(FLUSH_CYC - 1);
      end else if (flush_q) begin
         if (flush_cnt_q == '0) flush_d = 1'b0;
         else                   flush_cnt_d = flush_cnt_q - 1'b1;
      end

      case (state_q)
         ST_RUN, ST_FLUSH: begin
            drain_cnt_d = '0;
            if (bus.halt_req_i) state_d = ST_DRAIN;
            else                state_d = flush_d ? ST_FLUSH : ST_RUN;
         end
         ST_DRAIN: begin
            if (!bus.halt_req_i) begin
               drain_cnt_d = '0;
               state_d     = flush_d ? ST_FLUSH : ST_RUN;
            end else if (redirect || bus.ex_hold_i || bus.mem_hold_i) begin
               drain_cnt_d = '0;
            end else if (drain_cnt_q == 2'(DRAIN_CYC - 1)) begin
               drain_cnt_d = '0;
               state_d     = ST_HALTED;
            end else begin
               drain_cnt_d = drain_cnt_q + 2'd1;
            end
         end
         ST_HALTED: begin
            if (bus.resume_i) state_d = flush_d ? ST_FLUSH : ST_RUN;
         end
      endcase
   end

   // State register with synchronous active-low reset.
   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of statement order.
      if (!rst_n) begin
         state_q     <= ST_RUN;
         flush_q     <= 1'b0;
         flush_cnt_q <= '0;
         drain_cnt_q <= '0;
         halted_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         flush_q     <= flush_d;
         flush_cnt_q <= flush_cnt_d;
         drain_cnt_q <= drain_cnt_d;
         halted_q    <= (state_d == ST_HALTED);
      end
   end

   // Stall merge: halted/bus stall freeze everything; a redirect cycle must
   // let pc load the target, so only a bus stall may override it.
   always_comb begin
      hold = HOLD_NONE;
      if (!rst_n)                                     hold = HOLD_NONE;
      else if (state_q == ST_HALTED || bus.mem_hold_i) hold = HOLD_ALL;
      else if (redirect)                              hold = HOLD_NONE;
      else if (bus.ex_hold_i)                         hold = HOLD_PC_IF_ID;
      else if (state_q == ST_DRAIN)                   hold = HOLD_PC;
   end

   assign bus.exc_ack_o    = exc_ack;
   assign bus.int_ack_o    = int_ack;
   assign bus.jump_cause_o = cause;
   assign bus.jump_to_o    = jump_to;
   assign bus.jump_from_o  = jump_from;
   assign bus.hold_flag_o  = HOLD_W'(hold);
   assign bus.flush_o      = flush_q;
   assign bus.halted_o     = halted_q;

`ifdef PIPE_CTRL_PERF_EN
   logic [31:0] misp_cnt_q, int_cnt_q, exc_cnt_q, stall_cnt_q;
   logic        mispredict;

   assign mispredict = redirect && !exc_ack && !int_ack &&
                       ((cause == CAUSE_W'(CAUSE_PRED_NO_YES)) ||
                        (cause == CAUSE_W'(CAUSE_PRED_YES_NO)));

   // Free-running event counters; they wrap naturally at 2^32.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         misp_cnt_q  <= '0;
         int_cnt_q   <= '0;
         exc_cnt_q   <= '0;
         stall_cnt_q <= '0;
      end else begin
         if (mispredict)        misp_cnt_q  <= misp_cnt_q + 32'd1;
         if (int_ack)           int_cnt_q   <= int_cnt_q + 32'd1;
         if (exc_ack)           exc_cnt_q   <= exc_cnt_q + 32'd1;
         if (hold != HOLD_NONE) stall_cnt_q <= stall_cnt_q + 32'd1;
      end
   end

   assign mispredict_cnt_o = misp_cnt_q;
   assign int_cnt_o        = int_cnt_q;
   assign exc_cnt_o        = exc_cnt_q;
   assign stall_cnt_o      = stall_cnt_q;
`endif

endmodule
